mips_regfile: RTL and testbench

- General-purpose register file for the multi-cycle MIPS core: 32 x 32-bit registers, one synchronous write port, two combinational read ports.
- The core uses read port 0 for the rt/source-word operand and read port 1 for the rs/base operand.
- The core uses the write port for ALU, load and immediate write-back.
- R0 is hardwired to zero; the stack-pointer and return-address registers take defined values at reset.

---
 rtl/mips_regfile.sv | 65 ++++++
 tb/tb_mips_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// 32 x 32 general-purpose register file for the multi-cycle MIPS core: one write port, two combinational read ports.
// Optional macro REGFILE_WR_BYPASS_EN adds same-cycle write-through forwarding to both read ports.
module mips_regfile #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter logic [DATA_W-1:0]  SP_INIT = 32'h80120000,
  parameter logic [DATA_W-1:0]  RA_INIT = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [DATA_W-1:0] rd1_data
);

  localparam int NREGS  = 2 ** ADDR_W;
  localparam int SP_IDX = 29;
  localparam int RA_IDX = 31;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_live;

  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    if (idx == SP_IDX)      return SP_INIT;
    else if (idx == RA_IDX) return RA_INIT;
    else                    return '0;
  endfunction

  // R0 is never written, so its reset value of zero persists forever.
  assign wr_live = wr_en && (wr_num != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_num] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= reset_value(i);
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] num);
    logic [DATA_W-1:0] val;
    val = (num == '0) ? '0 : regs_q[num];
`ifdef REGFILE_WR_BYPASS_EN
    // Forward the in-flight write so the operand is valid in the write cycle.
    if (!reset && wr_live && (num == wr_num)) val = wr_data;
`endif
    return val;
  endfunction

  always_comb begin
    rd0_data = read_port(rd0_num);
    rd1_data = read_port(rd1_num);
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: reset values, directed vector table, corner sequences, random traffic vs. an array model.
module tb_mips_regfile;

  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 5;
  localparam logic [31:0] SP_INIT = 32'h80120000;
  localparam logic [31:0] RA_INIT = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  wr_num, rd0_num, rd1_num;
  logic [31:0] wr_data, rd0_data, rd1_data;
  logic        wr_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  mips_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_INIT(SP_INIT), .RA_INIT(RA_INIT)) dut (
    .clk(clk), .reset(reset),
    .wr_num(wr_num), .wr_data(wr_data), .wr_en(wr_en),
    .rd0_num(rd0_num), .rd0_data(rd0_data),
    .rd1_num(rd1_num), .rd1_data(rd1_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[29] = SP_INIT;
    model[31] = RA_INIT;
  endfunction

  // Value a read port should show right now, given the stored model and the live inputs.
  function automatic logic [31:0] model_read(input logic [4:0] num);
    logic [31:0] v;
    v = model[num];
`ifdef REGFILE_WR_BYPASS_EN
    if (!reset && wr_en && wr_num != 5'd0 && wr_num == num) v = wr_data;
`endif
    return v;
  endfunction

  // Wait for a rising edge, commit the write to the model, settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset && wr_en && wr_num != 5'd0) model[wr_num] = wr_data;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en = we; wr_num = wn; wr_data = wd; rd0_num = r0; rd1_num = r1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_reset();

    // Reset values through both ports while reset is held.
    #2;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      exp = (i == 29) ? 32'h80120000 : 32'h0;
      rd0_num = 5'(i);
      rd1_num = 5'(31 - i);
      #1;
      check($sformatf("reset_rd0_r%0d", i), rd0_data, exp);
      check($sformatf("reset_rd1_r%0d", 31 - i), rd1_data, (31 - i == 29) ? 32'h80120000 : 32'h0);
    end
    tick();
    #2 reset = 1'b0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 5'd3,  32'h00000011, 5'd3,  5'd5,  32'h11,       32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd4,  32'h00000022, 5'd3,  5'd4,  32'h11,       32'h22};
    vecs[5] = '{1'b0, 5'd4,  32'h00000099, 5'd4,  5'd4,  32'h22,       32'h22};
    vecs[6] = '{1'b1, 5'd29, 32'hCAFEF00D, 5'd29, 5'd31, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'h00001234, 5'd31, 5'd29, 32'h00001234, 32'hCAFEF00D};

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].we, vecs[v].wn, vecs[v].wd, vecs[v].r0, vecs[v].r1);
      tick();
      check($sformatf("vec%0d_rd0", v), rd0_data, vecs[v].e0);
      check($sformatf("vec%0d_rd1", v), rd1_data, vecs[v].e1);
    end

    // Read-during-write on R9.
    drive(1'b1, 5'd9, 32'hA, 5'd0, 5'd9);
    tick();
    drive(1'b1, 5'd9, 32'hB, 5'd9, 5'd9);
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    check("rdw_before_edge", rd1_data, 32'hB);
`else
    check("rdw_before_edge", rd1_data, 32'hA);
`endif
    tick();
    check("rdw_after_edge", rd1_data, 32'hB);
    wr_en = 1'b0;

    // Asynchronous reset between edges, writes blocked while reset is high.
    drive(1'b1, 5'd10, 32'h55, 5'd10, 5'd29);
    tick();
    check("r10_written", rd0_data, 32'h55);
    wr_en = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_r10", rd0_data, 32'h0);
    check("async_rst_sp", rd1_data, SP_INIT);
    drive(1'b1, 5'd10, 32'h77, 5'd10, 5'd5);
    #1;
    check("rst_no_fwd_r10", rd0_data, 32'h0);
    tick();
    check("rst_blocks_write", rd0_data, 32'h0);
    check("rst_cleared_r5", rd1_data, 32'h0);
    wr_en = 1'b0;
    #2 reset = 1'b0;
    drive(1'b1, 5'd10, 32'h66, 5'd10, 5'd10);
    tick();
    check("post_rst_write_rd0", rd0_data, 32'h66);
    check("post_rst_write_rd1", rd1_data, 32'h66);

    // Random traffic against the array model, checked before and after each edge.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) rd1_num = wr_num;
      #1;
      check($sformatf("rnd%0d_pre_rd0", n), rd0_data, model_read(rd0_num));
      check($sformatf("rnd%0d_pre_rd1", n), rd1_data, model_read(rd1_num));
      tick();
      check($sformatf("rnd%0d_post_rd0", n), rd0_data, model_read(rd0_num));
      check($sformatf("rnd%0d_post_rd1", n), rd1_data, model_read(rd1_num));
    end

    // Final sweep of every register with writes disabled.
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd0_num = 5'(i);
      rd1_num = 5'(i);
      #1;
      check($sformatf("sweep_rd0_r%0d", i), rd0_data, model[i]);
      check($sformatf("sweep_rd1_r%0d", i), rd1_data, model[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
